// File: rtl/fs_fault_injector.sv
// Stuck-at fault injector for the full-subtractor inputs (A, B, Bin).
// Data path is combinational pass-through; only the injection window control is registered.
module fs_fault_injector #(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_in,
  input  logic          b_in,
  input  logic          bin_in,
  output logic          a_out,
  output logic          b_out,
  output logic          bin_out,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [2:0]    cfg_mask,
  input  logic [2:0]    cfg_value,
  input  logic [DW-1:0] cfg_delay,
  input  logic [DW-1:0] cfg_duration,
  input  logic          clear,
  output logic          fault_active,
  output logic          done,
  output logic [CW-1:0] inj_count
);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

  state_t        r_state;
  logic [DW-1:0] r_cnt;
  logic [DW-1:0] r_dur;
  logic [2:0]    r_mask;
  logic [2:0]    r_value;
  logic          r_done;
  logic [CW-1:0] r_inj_count;
  logic [2:0]    w_force;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_dur       <= '0;
      r_mask      <= '0;
      r_value     <= '0;
      r_done      <= 1'b0;
      r_inj_count <= '0;
    end else begin
      r_done <= 1'b0;
      if (clear) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: if (cfg_valid) begin
            r_mask  <= cfg_mask;
            r_value <= cfg_value;
            r_dur   <= cfg_duration;
            r_cnt   <= cfg_delay;
            r_state <= (cfg_delay == '0) ? ACTIVE : ARMED;
          end
          ARMED: begin
            r_cnt <= r_cnt - DW'(1);
            if (r_cnt == DW'(1)) r_state <= ACTIVE;
          end
          ACTIVE: begin
            // r_dur == 0 means a permanent fault: only clear or reset ends it
            if (r_dur == DW'(1)) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
              if (r_inj_count != '1) r_inj_count <= r_inj_count + CW'(1);
            end else if (r_dur != '0) begin
              r_dur <= r_dur - DW'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Reset drops r_state asynchronously, so the force vanishes without a clock edge.
  assign w_force      = (r_state == ACTIVE) ? r_mask : 3'b000;
  assign a_out        = w_force[2] ? r_value[2] : a_in;
  assign b_out        = w_force[1] ? r_value[1] : b_in;
  assign bin_out      = w_force[0] ? r_value[0] : bin_in;
  assign fault_active = (r_state == ACTIVE);
  assign cfg_ready    = (r_state == IDLE);
  assign done         = r_done;
  assign inj_count    = r_inj_count;

endmodule

// File: tb/tb_fs_fault_injector.sv
// Bench for fs_fault_injector: absolute-time window model checked every cycle plus directed literal checks.
module tb_fs_fault_injector;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_in = 1'b0, b_in = 1'b0, bin_in = 1'b0;
  logic          cfg_valid = 1'b0, clear = 1'b0;
  logic [2:0]    cfg_mask = '0, cfg_value = '0;
  logic [DW-1:0] cfg_delay = '0, cfg_duration = '0;
  logic          a_out, b_out, bin_out, cfg_ready, fault_active, done;
  logic [CW-1:0] inj_count;

  fs_fault_injector #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_in(a_in), .b_in(b_in), .bin_in(bin_in),
    .a_out(a_out), .b_out(b_out), .bin_out(bin_out),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mask(cfg_mask), .cfg_value(cfg_value),
    .cfg_delay(cfg_delay), .cfg_duration(cfg_duration),
    .clear(clear), .fault_active(fault_active), .done(done),
    .inj_count(inj_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // Model: a window is an absolute edge interval [start, end) counted from reset.
  int       m_edge, m_start, m_end, m_cnt;
  bit       m_busy, m_perm, m_done;
  bit [2:0] m_mask, m_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edge <= 0; m_start <= 0; m_end <= 0; m_cnt <= 0;
      m_busy <= 0; m_perm <= 0; m_done <= 0; m_mask <= 0; m_val <= 0;
    end else begin
      m_edge <= m_edge + 1;
      m_done <= 0;
      if (clear) m_busy <= 0;
      else if (!m_busy) begin
        if (cfg_valid) begin
          m_busy  <= 1;
          m_start <= m_edge + 1 + int'(cfg_delay);
          m_end   <= m_edge + 1 + int'(cfg_delay) + int'(cfg_duration);
          m_perm  <= (cfg_duration == 0);
          m_mask  <= cfg_mask;
          m_val   <= cfg_value;
        end
      end else if (!m_perm && (m_edge + 1 == m_end)) begin
        m_busy <= 0;
        m_done <= 1;
        m_cnt  <= (m_cnt < SAT) ? m_cnt + 1 : SAT;
      end
    end
  end

  function automatic logic [9:0] model_vec();
    bit       fa;
    bit [2:0] f, o;
    fa = m_busy && (m_edge >= m_start);
    f  = fa ? m_mask : 3'b000;
    o  = (f & m_val) | (~f & {a_in, b_in, bin_in});
    return {o, fa, m_done, !m_busy, 4'(m_cnt)};
  endfunction

  always @(negedge clk)
    if (rst_n && chk_on)
      chk("cycle", 16'({a_out, b_out, bin_out, fault_active, done, cfg_ready, inj_count}),
          16'(model_vec()));

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic cfg(input logic [2:0] m, input logic [2:0] v, input int dl, input int du);
    cfg_mask = m; cfg_value = v; cfg_delay = DW'(dl); cfg_duration = DW'(du);
  endtask

  logic       ea[0:8] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
  logic       ed[0:8] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
  logic       er[0:8] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
  logic [2:0] v3;
  logic       d_o, bo_o;

  initial begin
    #12 rst_n = 1'b1;
    chk_on = 1'b1;
    chk("reset", 16'({fault_active, done, cfg_ready, inj_count}), 16'({3'b001, 4'd0}));
    for (int i = 0; i < 8; i++) begin
      v3 = 3'(i);
      {a_in, b_in, bin_in} = v3;
      #1 chk("passthru", 16'({a_out, b_out, bin_out}), 16'(v3));
    end

    // Delayed finite A stuck-at-0
    step();
    {a_in, b_in, bin_in} = 3'b111;
    cfg(3'b100, 3'b000, 3, 4);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      chk("winA", 16'({a_out, fault_active, done, cfg_ready}), 16'({ea[i], ~ea[i], ed[i], er[i]}));
      step();
    end
    chk("cnt1", 16'(inj_count), 16'd1);

    // Immediate B and Bin stuck-at-0
    cfg(3'b011, 3'b000, 0, 2);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d_o  = a_out ^ b_out ^ bin_out;
      bo_o = (~a_out & b_out) | (~(a_out ^ b_out) & bin_out);
      chk("winBBin", 16'({b_out, bin_out}), (i < 2) ? 16'd0 : 16'd3);
      if (i < 2) chk("subDBout", 16'({d_o, bo_o}), 16'b10);
      step();
    end
    chk("cnt2", 16'(inj_count), 16'd2);

    // Permanent all-ones fault, cfg offered while active, then clear
    {a_in, b_in, bin_in} = 3'b000;
    cfg(3'b111, 3'b111, 0, 0);
    cfg_valid = 1'b1;
    step();
    cfg(3'b100, 3'b000, 1, 1);
    cfg_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      {a_in, b_in, bin_in} = 3'($urandom_range(0, 7));
      cfg_valid = (i == 150);
      #1 chk("perm", 16'({a_out, b_out, bin_out, fault_active, cfg_ready}), 16'b11110);
      step();
    end
    cfg_valid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {a_in, b_in, bin_in} = 3'(i + 2);
      #1 chk("postclr", 16'({a_out, b_out, bin_out, fault_active, done, inj_count}),
             16'({3'(i + 2), 2'b00, 4'd2}));
      step();
    end

    // Clear and cfg_valid together in IDLE
    {a_in, b_in, bin_in} = 3'b000;
    cfg(3'b111, 3'b111, 0, 3);
    clear = 1'b1; cfg_valid = 1'b1;
    step();
    clear = 1'b0; cfg_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("clrcfg", 16'({fault_active, cfg_ready, a_out, b_out, bin_out}), 16'b01000);
      step();
    end

    // Async reset mid-window
    {a_in, b_in, bin_in} = 3'b111;
    cfg(3'b111, 3'b000, 0, 0);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    chk("prerst", 16'({fault_active, a_out, b_out, bin_out}), 16'b1000);
    #1 rst_n = 1'b0;
    #1 chk("asyncrst", 16'({fault_active, a_out, b_out, bin_out, cfg_ready, inj_count}),
           16'({5'b01111, 4'd0}));
    #2 rst_n = 1'b1;

    // Saturating injection counter over 20 back-to-back windows
    cfg(3'b100, 3'b000, 0, 1);
    cfg_valid = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 28) chk("cnt14", 16'(inj_count), 16'd14);
    end
    cfg_valid = 1'b0;
    step();
    chk("cntsat", 16'(inj_count), 16'(SAT));

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
